// File: rtl/collatz_range_engine.sv
// rtl/collatz_range_engine.sv - Collatz sequence-length sweep over RAM_WORDS consecutive start values
// One start value is processed at a time, one Collatz step per clock, results kept in a count RAM.
module collatz_range_engine #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int COUNT_BITS    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     go_i,
  input  logic [31:0]              start_i,
  input  logic [RAM_ADDR_BITS-1:0] n_i,
  output logic                     done_o,
  output logic [COUNT_BITS-1:0]    count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] LastIdx = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state_q;
  logic [31:0]              base_q;
  logic [RAM_ADDR_BITS-1:0] idx_q;
  logic [31:0]              v_q;
  logic [COUNT_BITS-1:0]    c_q;
  logic                     done_q;
  logic [COUNT_BITS-1:0]    count_q;
  logic [1:0]               rst_sync_q;
  logic                     rst_n_sync;

  logic [31:0]              v_load_d;
  logic [31:0]              v_step_d;
  logic [COUNT_BITS-1:0]    c_inc_d;

  logic [COUNT_BITS-1:0]    mem [RAM_WORDS];

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync = rst_sync_q[1];

  always_comb begin
    v_load_d = base_q + 32'(idx_q);
    v_step_d = v_q[0] ? ((v_q << 1) + v_q + 32'd1) : (v_q >> 1);
    c_inc_d  = (c_q == {COUNT_BITS{1'b1}}) ? c_q : c_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      v_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      count_q <= mem[n_i];
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go_i) begin
            base_q  <= start_i;
            idx_q   <= '0;
            done_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          v_q <= v_load_d;
          // A zero start has count 0 and skips iteration, keeping the c+2 entry latency.
          if (v_load_d == 32'd0) begin
            c_q     <= '0;
            state_q <= S_WRITE;
          end else begin
            c_q     <= COUNT_BITS'(1);
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          if (v_q == 32'd1 || v_q == 32'd0) begin
            state_q <= S_WRITE;
          end else begin
            v_q <= v_step_d;
            c_q <= c_inc_d;
          end
        end
        S_WRITE: begin
          if (idx_q == LastIdx) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Contents are deliberately not reset so a partial run survives a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (state_q == S_WRITE) begin
      mem[idx_q] <= c_q;
    end
  end

  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_collatz_range_engine.sv
// tb/tb_collatz_range_engine.sv - self-checking bench for collatz_range_engine
module tb_collatz_range_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go_s = 1'b0, go_b = 1'b0;
  logic [31:0] start_s = '0, start_b = '0;
  logic [1:0]  n_s = '0;
  logic [7:0]  n_b = '0;
  logic        done_s, done_b;
  logic [15:0] count_s, count_b;

  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  collatz_range_engine #(.RAM_WORDS(4), .RAM_ADDR_BITS(2), .COUNT_BITS(16)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .go_i(go_s), .start_i(start_s), .n_i(n_s),
    .done_o(done_s), .count_o(count_s)
  );

  collatz_range_engine u_big (
    .clk_i(clk), .rst_ni(rst_n), .go_i(go_b), .start_i(start_b), .n_i(n_b),
    .done_o(done_b), .count_o(count_b)
  );

  function automatic int unsigned ref_count(input logic [31:0] s);
    logic [31:0] v;
    int unsigned c;
    v = s;
    if (v == 0) return 0;
    c = 1;
    while (v != 1 && v != 0) begin
      if (v[0]) v = v * 32'd3 + 32'd1;
      else v = v / 2;
      if (c < 65535) c++;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_small(input int idx, output logic [15:0] val);
    n_s = idx[1:0];
    step();
    val = count_s;
  endtask

  task automatic read_big(input int idx, output logic [15:0] val);
    n_b = idx[7:0];
    step();
    val = count_b;
  endtask

  // Sweep on the 4-entry instance; optionally pulses go again (start=100) mid-run.
  task automatic run_small(input logic [31:0] st, input bit extra_go, input string tag);
    int unsigned exp_c[4];
    int unsigned exp_lat;
    int k;
    logic [15:0] val;
    exp_lat = 0;
    for (int i = 0; i < 4; i++) begin
      exp_c[i] = ref_count(st + 32'(i));
      exp_lat += exp_c[i] + 2;
    end
    start_s = st;
    go_s = 1'b1;
    step();
    go_s = 1'b0;
    check({tag, "_done_low"}, done_s, 0);
    k = 0;
    while (!done_s && k < 10000) begin
      step();
      k++;
      if (extra_go && k == 5) begin
        start_s = 32'd100;
        go_s = 1'b1;
      end else begin
        go_s = 1'b0;
      end
    end
    check({tag, "_latency"}, k, exp_lat);
    for (int i = 0; i < 4; i++) begin
      read_small(i, val);
      check($sformatf("%s_n%0d", tag, i), val, exp_c[i]);
    end
  endtask

  initial begin
    logic [15:0] val;
    int unsigned big_lat;
    int k;

    repeat (3) step();
    check("rst_done_s", done_s, 0);
    check("rst_count_s", count_s, 0);
    check("rst_done_b", done_b, 0);
    check("rst_count_b", count_b, 0);
    rst_n = 1'b1;
    repeat (4) step();

    run_small(32'd1, 1'b0, "basic");
    check("basic_lit_latency", ref_count(1) + ref_count(2) + ref_count(3) + ref_count(4) + 8, 22);
    run_small(32'd1, 1'b1, "ignored_go");
    run_small(32'd0, 1'b0, "zero_start");
    run_small(32'd6, 1'b0, "restart");
    read_small(0, val);
    check("restart_n0_lit", val, 9);

    run_small(32'hFFFF_FFFE, 1'b0, "add_wrap");
    run_small(32'h5555_5554, 1'b0, "mul_wrap");
    for (int r = 0; r < 5; r++) begin
      run_small($urandom, 1'b0, $sformatf("rand%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      run_small(32'($urandom_range(2, 5000)), 1'b0, $sformatf("rsmall%0d", r));
    end

    // Reset while the third entry is iterating.
    n_s = 2'd2;
    start_s = 32'd1;
    go_s = 1'b1;
    step();
    go_s = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("midrst_done", done_s, 0);
    check("midrst_count", count_s, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    read_small(0, val);
    check("midrst_keep_n0", val, 1);
    read_small(1, val);
    check("midrst_keep_n1", val, 2);
    run_small(32'd5, 1'b0, "after_rst");
    read_small(0, val);
    check("after_rst_n0_lit", val, 6);

    big_lat = 0;
    for (int i = 0; i < 256; i++) big_lat += ref_count(32'd27 + 32'(i)) + 2;
    start_b = 32'd27;
    go_b = 1'b1;
    step();
    go_b = 1'b0;
    check("big_done_low", done_b, 0);
    k = 0;
    while (!done_b && k < 60000) begin
      step();
      k++;
    end
    check("big_latency", k, big_lat);
    read_big(0, val);
    check("big_n0_lit", val, 112);
    read_big(1, val);
    check("big_n1_lit", val, 19);
    read_big(5, val);
    check("big_n5_lit", val, 6);
    for (int i = 0; i < 256; i++) begin
      read_big(i, val);
      check($sformatf("big_n%0d", i), val, ref_count(32'd27 + 32'(i)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
